// File: rtl/grid_frame_scheduler_pkg.sv
// Shared constants and FSM encoding for the shifter-grid frame scheduler.
// Grid geometry, column width, bullet owner codes and sequencer states.
package grid_frame_scheduler_pkg;

  localparam int NUM_COLS = 160;
  localparam int NUM_ROWS = 120;
  localparam int COL_W    = 8;

  localparam logic OWNER_PLAYER = 1'b0;
  localparam logic OWNER_ENEMY  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_LOAD  = 2'd2,
    ST_SHIFT = 2'd3
  } sched_state_t;

endpackage

// File: rtl/grid_frame_scheduler_frame_tick_gen.sv
// Frame tick divider: one-cycle o_tick_tc every TICK_DIV enabled clocks.
// The counter holds while disabled; i_step forces a single tick when idle.
module frame_tick_gen
  import grid_frame_scheduler_pkg::*;
#(
  parameter int TICK_DIV = 833333
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_step,
  input  logic i_fsm_idle,
  output logic o_tick_tc
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tc;

  assign w_tc = i_enable && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
    end
  end

  // A manual step only counts while frozen and between sequences.
  assign o_tick_tc = w_tc || (!i_enable && i_step && i_fsm_idle);

endmodule

// File: rtl/grid_frame_scheduler.sv
// Per-frame sequencer for the shifter grid: arbitrate shot requests, load, shift.
// Optional build macro SCHED_SINGLE_STEP_EN adds a `step` input for single-frame stepping.
module grid_frame_scheduler
  import grid_frame_scheduler_pkg::*;
#(
  parameter int TICK_DIV        = 833333,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int NUM_COLS        = grid_frame_scheduler_pkg::NUM_COLS,
  parameter int COL_W           = grid_frame_scheduler_pkg::COL_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
`ifdef SCHED_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic             player_shoot,
  input  logic [COL_W-1:0] player_x,
  input  logic             enemy_fire,
  input  logic [COL_W-1:0] enemy_x,
  output logic             load_en,
  output logic [COL_W-1:0] load_col,
  output logic             load_owner,
  output logic             grid_update_en,
  output logic             player_ack,
  output logic             enemy_ack,
  output logic [15:0]      frame_count
);

  localparam int CD_W = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);

  sched_state_t     r_state;
  logic             r_shoot_d;
  logic             r_p_pend;
  logic             r_e_pend;
  logic [COL_W-1:0] r_p_col;
  logic [COL_W-1:0] r_e_col;
  logic             r_last_grant;
  logic             r_gnt_p;
  logic             r_gnt_e;
  logic [CD_W-1:0]  r_cooldown;
  logic             r_load_en;
  logic [COL_W-1:0] r_load_col;
  logic             r_load_owner;
  logic             r_grid_update_en;
  logic             r_player_ack;
  logic             r_enemy_ack;
  logic [15:0]      r_frame_count;

  logic w_tick_tc;
  logic w_step;
  logic w_p_edge;
  logic w_gp;
  logic w_ge;
  logic w_p_in_range;
  logic w_e_in_range;

`ifdef SCHED_SINGLE_STEP_EN
  assign w_step = step;
`else
  assign w_step = 1'b0;
`endif

  frame_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .i_clock    (clock),
    .i_reset    (reset),
    .i_enable   (enable),
    .i_step     (w_step),
    .i_fsm_idle (r_state == ST_IDLE),
    .o_tick_tc  (w_tick_tc)
  );

  assign w_p_edge     = player_shoot && !r_shoot_d;
  assign w_p_in_range = (32'(r_p_col) < 32'(NUM_COLS));
  assign w_e_in_range = (32'(r_e_col) < 32'(NUM_COLS));

  // On a tie the side that did not win the previous tie gets the slot.
  always_comb begin
    w_gp = 1'b0;
    w_ge = 1'b0;
    if (r_p_pend && r_e_pend) begin
      if (r_last_grant == OWNER_ENEMY) w_gp = 1'b1;
      else                             w_ge = 1'b1;
    end else begin
      w_gp = r_p_pend;
      w_ge = r_e_pend;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_shoot_d        <= 1'b0;
      r_p_pend         <= 1'b0;
      r_e_pend         <= 1'b0;
      r_p_col          <= '0;
      r_e_col          <= '0;
      r_last_grant     <= OWNER_ENEMY;
      r_gnt_p          <= 1'b0;
      r_gnt_e          <= 1'b0;
      r_cooldown       <= '0;
      r_load_en        <= 1'b0;
      r_load_col       <= '0;
      r_load_owner     <= OWNER_PLAYER;
      r_grid_update_en <= 1'b0;
      r_player_ack     <= 1'b0;
      r_enemy_ack      <= 1'b0;
      r_frame_count    <= '0;
    end else begin
      r_shoot_d <= player_shoot;

      // The pending clear in LOAD beats a request arriving in the same cycle.
      if (r_state == ST_LOAD && r_gnt_p) begin
        r_p_pend <= 1'b0;
      end else if (w_p_edge && r_cooldown == '0 && !r_p_pend) begin
        r_p_pend <= 1'b1;
        r_p_col  <= player_x;
      end

      if (r_state == ST_LOAD && r_gnt_e) begin
        r_e_pend <= 1'b0;
      end else if (enemy_fire && !r_e_pend) begin
        r_e_pend <= 1'b1;
        r_e_col  <= enemy_x;
      end

      r_load_en        <= 1'b0;
      r_player_ack     <= 1'b0;
      r_enemy_ack      <= 1'b0;
      r_grid_update_en <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_tick_tc) r_state <= ST_ARB;
        end
        ST_ARB: begin
          r_gnt_p      <= w_gp;
          r_gnt_e      <= w_ge;
          r_player_ack <= w_gp;
          r_enemy_ack  <= w_ge;
          if (w_gp) begin
            r_load_en    <= w_p_in_range;
            r_load_col   <= r_p_col;
            r_load_owner <= OWNER_PLAYER;
          end else if (w_ge) begin
            r_load_en    <= w_e_in_range;
            r_load_col   <= r_e_col;
            r_load_owner <= OWNER_ENEMY;
          end
          if (r_p_pend && r_e_pend) begin
            r_last_grant <= w_gp ? OWNER_PLAYER : OWNER_ENEMY;
          end
          r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_grid_update_en <= 1'b1;
          if (r_gnt_p) r_cooldown <= CD_LOAD;
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_frame_count <= r_frame_count + 16'd1;
          if (r_cooldown != '0) r_cooldown <= r_cooldown - 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign load_en        = r_load_en;
  assign load_col       = r_load_col;
  assign load_owner     = r_load_owner;
  assign grid_update_en = r_grid_update_en;
  assign player_ack     = r_player_ack;
  assign enemy_ack      = r_enemy_ack;
  assign frame_count    = r_frame_count;

endmodule

// File: tb/tb_grid_frame_scheduler.sv
// Directed bench for grid_frame_scheduler with TICK_DIV=10, COOLDOWN_FRAMES=2.
// Cycle numbers below count posedges after reset release (tick_tc at 9, 19, ...).
module tb_grid_frame_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       step = 1'b0;
  logic       player_shoot = 1'b0;
  logic [7:0] player_x = '0;
  logic       enemy_fire = 1'b0;
  logic [7:0] enemy_x = '0;
  logic       load_en;
  logic [7:0] load_col;
  logic       load_owner;
  logic       grid_update_en;
  logic       player_ack;
  logic       enemy_ack;
  logic [15:0] frame_count;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_overlap = 0;

  always #5 clock = ~clock;

  grid_frame_scheduler #(
    .TICK_DIV        (10),
    .COOLDOWN_FRAMES (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
`ifdef SCHED_SINGLE_STEP_EN
    .step           (step),
`endif
    .player_shoot   (player_shoot),
    .player_x       (player_x),
    .enemy_fire     (enemy_fire),
    .enemy_x        (enemy_x),
    .load_en        (load_en),
    .load_col       (load_col),
    .load_owner     (load_owner),
    .grid_update_en (grid_update_en),
    .player_ack     (player_ack),
    .enemy_ack      (enemy_ack),
    .frame_count    (frame_count)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clock);
    #1;
    cyc++;
    if (load_en && grid_update_en) n_overlap++;
  endtask

  // Advance until grid_update_en (bounded), recording load/ack activity seen.
  task automatic frame(output logic got, output int g_cyc, output logic ld,
                       output int ld_col, output logic ld_own, output int ld_cyc,
                       output logic pa, output logic ea);
    got = 0; g_cyc = -1; ld = 0; ld_col = -1; ld_own = 0; ld_cyc = -1; pa = 0; ea = 0;
    for (int i = 0; i < 30; i++) begin
      tick1();
      if (load_en) begin
        ld = 1; ld_col = int'(load_col); ld_own = load_owner; ld_cyc = cyc;
      end
      if (player_ack) pa = 1;
      if (enemy_ack)  ea = 1;
      if (grid_update_en) begin
        got = 1; g_cyc = cyc;
        break;
      end
    end
    $display("frame: gue=%0b at cyc %0d load=%0b col=%0d owner=%0b pack=%0b eack=%0b",
             got, g_cyc, ld, ld_col, ld_own, pa, ea);
  endtask

  logic got, ld, own, pa, ea;
  int   gc, lcol, lcyc, x0;

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_load_en", load_en, 0);
    chk("rst_gue", grid_update_en, 0);
    chk("rst_pack", player_ack, 0);
    chk("rst_eack", enemy_ack, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_load_col", load_col, 0);
    reset = 0; enable = 1; cyc = 0;

    // Idle frames: gue 3 cycles after each tick, no loads
    frame(got, gc, ld, lcol, own, lcyc, pa, ea);
    chk("idle1_gue_cyc", gc, 12); chk("idle1_no_load", ld, 0);
    frame(got, gc, ld, lcol, own, lcyc, pa, ea);
    chk("idle2_gue_cyc", gc, 22);
    frame(got, gc, ld, lcol, own, lcyc, pa, ea);
    chk("idle3_gue_cyc", gc, 32); chk("idle3_no_load", ld, 0);
    tick1();
    chk("idle_frame_count", frame_count, 3);

    // Player shot; column captured at request time
    player_shoot = 1; player_x = 42;
    tick1();
    player_shoot = 0; player_x = 50;
    frame(got, gc, ld, lcol, own, lcyc, pa, ea);
    chk("p42_load", ld, 1); chk("p42_col", lcol, 42); chk("p42_owner", own, 0);
    chk("p42_pack", pa, 1); chk("p42_eack", ea, 0);
    chk("p42_load_cyc", lcyc, 41); chk("p42_gue_cyc", gc, 42);

    frame(got, gc, ld, lcol, own, lcyc, pa, ea);
    chk("quiet_gue_cyc", gc, 52); chk("quiet_no_load", ld, 0);

    // Tie: player wins first (last grant starts as enemy), enemy next frame
    tick1();
    player_shoot = 1; player_x = 5; enemy_fire = 1; enemy_x = 90;
    tick1();
    player_shoot = 0; enemy_fire = 0;
    frame(got, gc, ld, lcol, own, lcyc, pa, ea);
    chk("tie1_col", lcol, 5); chk("tie1_owner", own, 0);
    chk("tie1_pack", pa, 1); chk("tie1_eack", ea, 0); chk("tie1_gue_cyc", gc, 62);
    frame(got, gc, ld, lcol, own, lcyc, pa, ea);
    chk("tie1b_col", lcol, 90); chk("tie1b_owner", own, 1); chk("tie1b_eack", ea, 1);
    chk("tie1b_pack", pa, 0);

    // Tie again: enemy wins this time
    tick1();
    player_shoot = 1; player_x = 6; enemy_fire = 1; enemy_x = 91;
    tick1();
    player_shoot = 0; enemy_fire = 0;
    frame(got, gc, ld, lcol, own, lcyc, pa, ea);
    chk("tie2_col", lcol, 91); chk("tie2_owner", own, 1); chk("tie2_pack", pa, 0);
    frame(got, gc, ld, lcol, own, lcyc, pa, ea);
    chk("tie2b_col", lcol, 6); chk("tie2b_owner", own, 0); chk("tie2b_gue_cyc", gc, 92);

    // Cooldown: two edges dropped, edge after cooldown expires granted
    tick1();
    player_shoot = 1; player_x = 7;
    tick1();
    player_shoot = 0;
    tick1();
    player_shoot = 1; player_x = 8;
    tick1();
    player_shoot = 0;
    frame(got, gc, ld, lcol, own, lcyc, pa, ea);
    chk("cd_no_load", ld, 0); chk("cd_no_pack", pa, 0); chk("cd_gue_cyc", gc, 102);
    tick1();
    player_shoot = 1; player_x = 9;
    tick1();
    player_shoot = 0;
    frame(got, gc, ld, lcol, own, lcyc, pa, ea);
    chk("cd_after_col", lcol, 9); chk("cd_after_pack", pa, 1);

    // Out-of-range enemy column: ack but no load, shift still fires
    tick1();
    enemy_fire = 1; enemy_x = 200;
    tick1();
    enemy_fire = 0;
    frame(got, gc, ld, lcol, own, lcyc, pa, ea);
    chk("oor_eack", ea, 1); chk("oor_no_load", ld, 0);
    chk("oor_gue", got, 1); chk("oor_gue_cyc", gc, 122);

    // Reset asserted in the LOAD cycle
    tick1();
    enemy_fire = 1; enemy_x = 30;
    tick1();
    enemy_fire = 0;
    repeat (7) tick1();
    chk("rl_cyc", cyc, 131);
    chk("rl_load_en", load_en, 1); chk("rl_load_col", load_col, 30);
    reset = 1;
    tick1();
    chk("rl_after_load_en", load_en, 0); chk("rl_after_gue", grid_update_en, 0);
    chk("rl_after_eack", enemy_ack, 0); chk("rl_after_frame_count", frame_count, 0);
    tick1();
    chk("rl_no_gue", grid_update_en, 0);
    reset = 0; enable = 1;

    // Fresh start after reset; pending request was cleared
    frame(got, gc, ld, lcol, own, lcyc, pa, ea);
    chk("post_rst_gue_cyc", gc, 145); chk("post_rst_no_load", ld, 0);
    tick1();
    chk("post_rst_frame_count", frame_count, 1);

    // enable drops during ARB: the frame still completes, then freezes
    repeat (7) tick1();
    enable = 0;
    frame(got, gc, ld, lcol, own, lcyc, pa, ea);
    chk("en_drop_gue_cyc", gc, 155);
    tick1();
    chk("en_drop_frame_count", frame_count, 2);
    frame(got, gc, ld, lcol, own, lcyc, pa, ea);
    chk("frozen_no_gue", got, 0); chk("frozen_frame_count", frame_count, 2);

`ifdef SCHED_SINGLE_STEP_EN
    x0 = cyc;
    step = 1;
    tick1();
    step = 0;
    frame(got, gc, ld, lcol, own, lcyc, pa, ea);
    chk("step_gue_cyc", gc, x0 + 3);
    frame(got, gc, ld, lcol, own, lcyc, pa, ea);
    chk("step_single", got, 0); chk("step_frame_count", frame_count, 3);
`endif

    chk("no_load_shift_overlap", n_overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/grid_frame_scheduler.md
Name: grid_frame_scheduler

Overview:
- Sequences the 160x120 shifter grid once per game frame: divides `clock` into a frame tick and runs a fixed three-step sequence (arbitrate, load, shift).
- Arbitrates player and enemy shot requests for the one load slot each frame.
- Drives the grid's per-column load and its shared shift-enable (`gridUpdateEn`).
- Sits between the input and enemy logic and the shifter grid.

Parameters:
- TICK_DIV, 833333, clocks per frame (60 Hz at 50 MHz); must be >= 4.
- COOLDOWN_FRAMES, 8, frames a player must wait after a granted shot.
- NUM_COLS, 160, number of valid columns; valid columns are 0..NUM_COLS-1.
- COL_W, 8, column index width.

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high; clears all state on a rising edge of `clock`.
- enable  in  1  game running; 0 freezes frame generation.
- player_shoot  in  1  level input from a switch; only its rising edge requests a shot.
- player_x  in  COL_W  player column.
- enemy_fire  in  1  one-cycle enemy shot request.
- enemy_x  in  COL_W  enemy column.
- load_en  out  1  one-cycle pulse: load a bullet into column `load_col`.
- load_col  out  COL_W  column to load; valid while `load_en` is 1.
- load_owner  out  1  0 = player, 1 = enemy; valid while `load_en` is 1.
- grid_update_en  out  1  one-cycle shift pulse; drives `gridUpdateEn` of the grid.
- player_ack  out  1  one-cycle pulse when the player request is granted.
- enemy_ack  out  1  one-cycle pulse when the enemy request is granted.
- frame_count  out  16  count of completed shifts; wraps at 2^16.

Behaviour:
- Reset values:
  - All outputs 0.
  - Tick counter 0, FSM in IDLE.
  - Both pending flags 0, cooldown 0.
  - `last_grant` = ENEMY, so the player wins the first tie.
- Tick counter:
  - Counts 0..TICK_DIV-1 while `enable` = 1; terminal count asserts `tick_tc` for one cycle, then the counter wraps to 0.
  - While `enable` = 0 the counter holds its value.
- FSM states and transitions:
  - IDLE -> ARB on `tick_tc`.
  - ARB -> LOAD unconditionally.
  - LOAD -> SHIFT unconditionally.
  - SHIFT -> IDLE unconditionally.
- Fixed latency, with `tick_tc` in cycle T:
  - ARB in T+1.
  - `load_en`/ack in T+2 (only if there is a grant).
  - `grid_update_en` in T+3.
  - Back to IDLE in T+4.
- `enable` falling mid-sequence does not abort the sequence; the current frame completes.
- Player request:
  - A rising edge of `player_shoot` (edge detector registered on `clock`) with cooldown = 0 and no pending request sets `p_pend` and latches `player_x` into `p_col`.
  - Edges during cooldown, or while already pending, are dropped.
- Enemy request:
  - `enemy_fire` = 1 with no pending enemy request sets `e_pend` and latches `enemy_x`.
  - Later pulses while pending are dropped.
- Columns are captured at request time; later movement does not change the load column.
- ARB:
  - Only one pending -> grant it.
  - Both pending -> grant the side that is not `last_grant`, then update `last_grant`.
  - The loser stays pending for the next frame.
- LOAD:
  - The granted owner's ack pulses and its pending flag clears.
  - `load_en` pulses only if the latched column < NUM_COLS.
  - Out-of-range column: ack is still issued, no load, pending flag still clears.
- Request and ack in the same cycle: the clear wins; a new request is accepted from the next cycle.
- Cooldown:
  - A player grant loads COOLDOWN_FRAMES.
  - Cooldown decrements by 1 on each SHIFT, saturating at 0.
- `frame_count` increments on each SHIFT.
- `load_en` and `grid_update_en` are never asserted in the same cycle.
- Reset asserted mid-sequence: the next clock returns everything to reset values; no partial pulses follow.

Optional Feature:
- Macro: SCHED_SINGLE_STEP_EN.
- Defined:
  - Adds input `step` (1 bit).
  - While `enable` = 0, a `step` pulse forces `tick_tc` for one cycle, so exactly one frame sequence runs.
  - `step` is ignored while `enable` = 1 or the FSM is not IDLE.
- Not defined: no `step` port; `enable` = 0 fully freezes frame generation.

Decomposition:
- Shared package/header holds:
  - NUM_COLS = 160 and NUM_ROWS = 120.
  - COL_W = 8.
  - OWNER_PLAYER = 0 and OWNER_ENEMY = 1.
  - The FSM state encoding (IDLE, ARB, LOAD, SHIFT).
- One sub-module: `frame_tick_gen`. It contains the TICK_DIV counter, the enable hold and the `step` override, and outputs `tick_tc`.

Test Plan (TICK_DIV = 10, COOLDOWN_FRAMES = 2):
- Reset, then `enable` = 1 with no requests -> `grid_update_en` pulses every 10 cycles, 3 cycles after each `tick_tc`. `load_en` stays 0. `frame_count` = 3 after 3 frames.
- Player edge with `player_x` = 42, then `player_x` changed to 50 before the tick -> `load_en` = 1 with `load_col` = 42 and `load_owner` = 0, plus a `player_ack` pulse, one cycle before `grid_update_en`.
- Player (x = 5) and enemy (x = 90) both pending -> frame 1 loads col 5 (player), frame 2 loads col 90 (enemy). Repeat with both pending -> enemy is granted first this time.
- Player shot granted, then player edges during the next 2 frames -> both ignored. An edge after cooldown reaches 0 is granted.
- Enemy request with `enemy_x` = 200 -> `enemy_ack` pulses, `load_en` stays 0, `grid_update_en` still fires.
- Reset asserted in the LOAD cycle -> next cycle all outputs 0 and no `grid_update_en` for that frame. With `enable` = 0, `frame_count` is frozen. With SCHED_SINGLE_STEP_EN, one `step` pulse gives exactly one `grid_update_en`.
